// File: rtl/store_buffer.sv
// Store buffer between the pipeline and a single-ported data memory.
// Buffers stores in a circular FIFO, forwards to loads, and drains when the port is free.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     stall,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [31:0]              address,
  output logic [31:0]              write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic             full;
  logic             empty;
  logic             enq;
  logic             drain;
  logic             hit_c;
  logic [31:0]      hit_data_c;
  logic [PW-1:0]    idx;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit_c      = 1'b0;
    hit_data_c = '0;
    idx        = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ld_valid && ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
        hit_c      = 1'b1;
        hit_data_c = ent_data[idx];
      end
    end
  end

  always_comb begin
    stall      = 1'b0;
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    address    = '0;
    write_data = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (!reset) begin
      fwd_hit  = hit_c;
      fwd_data = hit_data_c;
      stall    = st_valid && full;
      // A full buffer must drain to make progress; only forwarded loads may proceed.
      if (full) begin
        mem_write  = 1'b1;
        address    = ent_addr[head];
        write_data = ent_data[head];
        if (ld_valid && !hit_c) begin
          stall = 1'b1;
        end
      end else if (ld_valid) begin
        mem_read = 1'b1;
        address  = ld_addr;
      end else if (!empty) begin
        mem_write  = 1'b1;
        address    = ent_addr[head];
        write_data = ent_data[head];
      end
    end
  end

  assign enq   = st_valid && !full && !reset;
  assign drain = mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (enq) begin
        ent_addr[tail]  <= st_addr;
        ent_data[tail]  <= st_data;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count + CW'(enq) - CW'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, forwarding, full/stall arbitration and reset.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        stall;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .stall      (stall),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .address    (address),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic lv, input logic [31:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 32'd5, 32'd5, 1'b1, 32'd5);
    step();
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_address", address, 32'd0);
    step();

    // Single store drains on the following cycle
    reset = 1'b0;
    applyStimulus(1'b1, 32'd8, 32'd45, 1'b0, 32'd0);
    checkOutput("s1_count0", 32'(count), 32'd0);
    checkOutput("s1_nowrite", 32'(mem_write), 32'd0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("s1_count1", 32'(count), 32'd1);
    checkOutput("s1_mem_write", 32'(mem_write), 32'd1);
    checkOutput("s1_address", address, 32'd8);
    checkOutput("s1_wdata", write_data, 32'd45);
    step();
    checkOutput("s1_count_end", 32'(count), 32'd0);
    checkOutput("s1_idle_write", 32'(mem_write), 32'd0);
    checkOutput("s1_idle_addr", address, 32'd0);

    // Two stores to the same address, youngest forwarded
    applyStimulus(1'b1, 32'd8, 32'd1, 1'b1, 32'd100);
    checkOutput("s2_nohit", 32'(fwd_hit), 32'd0);
    step();
    applyStimulus(1'b1, 32'd8, 32'd2, 1'b1, 32'd8);
    checkOutput("s2_hit_old", 32'(fwd_hit), 32'd1);
    checkOutput("s2_data_old", fwd_data, 32'd1);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd8);
    checkOutput("s2_hit", 32'(fwd_hit), 32'd1);
    checkOutput("s2_data_young", fwd_data, 32'd2);
    checkOutput("s2_mem_read", 32'(mem_read), 32'd1);
    checkOutput("s2_no_drain", 32'(mem_write), 32'd0);
    checkOutput("s2_count", 32'(count), 32'd2);
    step();
    checkOutput("s2_count_hold", 32'(count), 32'd2);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("s2_fwd_data_idle", fwd_data, 32'd0);
    checkOutput("s2_drain0", write_data, 32'd1);
    step();
    checkOutput("s2_drain1", write_data, 32'd2);
    step();
    checkOutput("s2_empty", 32'(count), 32'd0);

    // Fill to four with the load holding the port, then a fifth store stalls
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(16 + 4 * i), 32'(8'hA0 + i), 1'b1, 32'd200);
      step();
    end
    checkOutput("s3_full_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 32'd32, 32'hA4, 1'b1, 32'd200);
    checkOutput("s3_stall", 32'(stall), 32'd1);
    checkOutput("s3_count4", 32'(count), 32'd4);
    checkOutput("s3_no_read", 32'(mem_read), 32'd0);
    checkOutput("s3_drain_addr", address, 32'd16);
    checkOutput("s3_drain_data", write_data, 32'hA0);
    step();
    applyStimulus(1'b1, 32'd32, 32'hA4, 1'b0, 32'd0);
    checkOutput("s3_released", 32'(stall), 32'd0);
    checkOutput("s3_count3", 32'(count), 32'd3);
    checkOutput("s3_drain2", address, 32'd20);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("s3_enq_drain_count", 32'(count), 32'd3);
    checkOutput("s3_drain3", address, 32'd24);
    step();
    checkOutput("s3_drain4", address, 32'd28);
    step();
    checkOutput("s3_wrap_addr", address, 32'd32);
    checkOutput("s3_wrap_data", write_data, 32'hA4);
    step();
    checkOutput("s3_empty", 32'(count), 32'd0);

    // Full buffer with unmatched and matching loads
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(40 + 4 * i), 32'(i + 1), 1'b1, 32'd200);
      step();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd9);
    checkOutput("s4_miss_stall", 32'(stall), 32'd1);
    checkOutput("s4_miss_read", 32'(mem_read), 32'd0);
    checkOutput("s4_miss_write", 32'(mem_write), 32'd1);
    checkOutput("s4_miss_addr", address, 32'd40);
    step();
    applyStimulus(1'b1, 32'd56, 32'd5, 1'b1, 32'd200);
    checkOutput("s4_refill_read", 32'(mem_read), 32'd1);
    checkOutput("s4_refill_count", 32'(count), 32'd3);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd44);
    checkOutput("s4_hit_stall", 32'(stall), 32'd0);
    checkOutput("s4_hit", 32'(fwd_hit), 32'd1);
    checkOutput("s4_hit_draining", fwd_data, 32'd2);
    checkOutput("s4_hit_drain_addr", address, 32'd44);
    step();
    checkOutput("s4_count_after", 32'(count), 32'd3);
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    step();
    reset = 1'b0;

    // Store alongside a load to the same address is not forwarded that cycle
    applyStimulus(1'b1, 32'd12, 32'h77, 1'b1, 32'd12);
    checkOutput("s5_same_cycle_hit", 32'(fwd_hit), 32'd0);
    checkOutput("s5_read", 32'(mem_read), 32'd1);
    checkOutput("s5_read_addr", address, 32'd12);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd12);
    checkOutput("s5_next_hit", 32'(fwd_hit), 32'd1);
    checkOutput("s5_next_data", fwd_data, 32'h77);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd12);
    checkOutput("s5_idle_hit", 32'(fwd_hit), 32'd0);
    checkOutput("s5_drain_data", write_data, 32'h77);
    step();

    // Reset with three entries buffered discards them
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(60 + 4 * i), 32'(i + 9), 1'b1, 32'd200);
      step();
    end
    checkOutput("s6_count3", 32'(count), 32'd3);
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("s6_rst_write", 32'(mem_write), 32'd0);
    checkOutput("s6_rst_addr", address, 32'd0);
    step();
    checkOutput("s6_rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("s6_after_write", 32'(mem_write), 32'd0);
    checkOutput("s6_after_count", 32'(count), 32'd0);
    step();
    checkOutput("s6_after_write2", 32'(mem_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
